// File: rtl/gate_vector_decoder.sv
// gate_vector_decoder: receive side of the 7-bit gate-output vector
// {XNOR,XOR,NOR,NAND,OR,AND,NOT(a)}. Recovers a/b, flags vectors that do not
// re-encode exactly, counts accepted and bad vectors, and stops taking input
// once ERR_LIMIT bad vectors have arrived since the last clr_err.
module gate_vector_decoder #(
    parameter int CNT_W     = 16,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_a,
    output logic             out_b,
    output logic             out_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sticky_err,
    output logic [6:0]       first_bad
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(ERR_LIMIT);
    localparam logic             HALT_EN   = (ERR_LIMIT != 0);

    state_t state, state_next;

    // decode stage (combinational)
    logic a_p0, b_p0, err_p0;
    // output register stage
    logic vld_p1, a_p1, b_p1, err_p1;

    logic             accept;
    logic             halt_hit;
    logic [CNT_W-1:0] err_base, err_next;
    logic             sticky_base, sticky_next;
    logic [6:0]       first_base, first_next;

    // Re-encode a,b into the gate vector, bit0 = ~a ... bit6 = ~(a^b).
    function automatic logic [6:0] encode(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Ready is forced low while reset is held so nothing is taken mid-reset.
    assign in_ready  = rst_n & (state == RUN) & (~vld_p1 | out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_p1;
    assign out_a     = a_p1;
    assign out_b     = b_p1;
    assign out_err   = err_p1;

    // Recover operands from NOT(a) and XOR bits, then compare the full vector.
    always_comb begin
        a_p0   = ~in_vec[0];
        b_p0   = in_vec[5] ^ a_p0;
        err_p0 = (in_vec != encode(a_p0, b_p0));
    end

    // Error bookkeeping: clr_err is applied first, then a bad accept counts on top.
    always_comb begin
        err_base    = clr_err ? '0   : err_cnt;
        sticky_base = clr_err ? 1'b0 : sticky_err;
        first_base  = clr_err ? '0   : first_bad;
        err_next    = err_base;
        sticky_next = sticky_base;
        first_next  = first_base;
        if (accept && err_p0) begin
            err_next = sat_inc(err_base);
            if (!sticky_base) begin
                sticky_next = 1'b1;
                first_next  = in_vec;
            end
        end
        halt_hit = accept & err_p0 & HALT_EN & (err_next == LIMIT_CNT);
    end

    // Next-state logic: a clear releases HALT, hitting the limit enters it.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_hit) state_next = HALT;
            HALT:    if (clr_err)  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // ---- stage p0 -> p1: result register, held while downstream stalls ----
    // Load on accept, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= 1'b0;
            b_p1   <= 1'b0;
            err_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            a_p1   <= a_p0;
            b_p1   <= b_p0;
            err_p1 <= err_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Vector and error counters plus first-bad capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt    <= '0;
            err_cnt    <= '0;
            sticky_err <= 1'b0;
            first_bad  <= '0;
        end else begin
            if (accept) vec_cnt <= sat_inc(vec_cnt);
            err_cnt    <= err_next;
            sticky_err <= sticky_next;
            first_bad  <= first_next;
        end
    end

endmodule
